// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared mult/div units: launches one op, waits for the unit's stop,
// then commits Hi/Lo or reports divide-by-zero / timeout to the control FSM.
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 48,
    parameter int CNT_W          = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             abort,
    input  logic             mult_stop,
    input  logic             div_stop,
    input  logic             div_zero,
    output logic             mult_control,
    output logic             div_control,
    output logic             HiLo_load,
    output logic             sel_mux_hi,
    output logic             sel_mux_lo,
    output logic             busy,
    output logic             done,
    output logic             exc_div_zero,
    output logic             exc_timeout,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, WRITE, EXC} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             op_q, op_d;      // 1 = mult, 0 = div
    logic             kind_q, kind_d;  // 1 = timeout, 0 = divide-by-zero
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_stop;

    assign active_stop = op_q ? mult_stop : div_stop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            kind_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_mult) begin
                    op_d    = 1'b1;
                    state_d = LAUNCH;
                end else if (start_div) begin
                    op_d    = 1'b0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = abort ? IDLE : WAIT;
            end
            WAIT: begin
                // Counter also advances on the exit edge so it reads as WAIT cycles spent.
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (!op_q && div_zero) begin
                    kind_d  = 1'b0;
                    state_d = EXC;
                end else if (active_stop) begin
                    state_d = WRITE;
                end else if (cnt_q == CNT_MAX) begin
                    kind_d  = 1'b1;
                    state_d = EXC;
                end
            end
            WRITE:   state_d = IDLE;
            EXC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mult_control = (state_q == LAUNCH) &&  op_q;
    assign div_control  = (state_q == LAUNCH) && !op_q;
    assign HiLo_load    = (state_q == WRITE);
    assign done         = (state_q == WRITE);
    assign exc_div_zero = (state_q == EXC) && !kind_q;
    assign exc_timeout  = (state_q == EXC) &&  kind_q;
    assign busy         = (state_q != IDLE);
    assign sel_mux_hi   = op_q;
    assign sel_mux_lo   = op_q;
    assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, random transactions against an
// outcome-level model, plus abort-in-launch and asynchronous reset sequences.
module tb_muldiv_sequencer;

    localparam int TO      = 48;
    localparam int K_DONE  = 0;
    localparam int K_ZERO  = 1;
    localparam int K_TO    = 2;
    localparam int K_ABORT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_mult = 1'b0, start_div = 1'b0, abort = 1'b0;
    logic       mult_stop = 1'b0, div_stop = 1'b0, div_zero = 1'b0;
    logic       mult_control, div_control, HiLo_load, sel_mux_hi, sel_mux_lo;
    logic       busy, done, exc_div_zero, exc_timeout;
    logic [5:0] cycle_count;

    logic [31:0] A = 32'd0, B = 32'd0, hi_r = 32'd0, lo_r = 32'd0;
    logic [63:0] prod;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .abort(abort), .mult_stop(mult_stop), .div_stop(div_stop), .div_zero(div_zero),
        .mult_control(mult_control), .div_control(div_control), .HiLo_load(HiLo_load),
        .sel_mux_hi(sel_mux_hi), .sel_mux_lo(sel_mux_lo), .busy(busy), .done(done),
        .exc_div_zero(exc_div_zero), .exc_timeout(exc_timeout), .cycle_count(cycle_count)
    );

    // Hi/Lo registers fed by ideal mult/div results through the sequencer's muxes.
    assign prod = {32'd0, A} * {32'd0, B};
    always @(posedge clk) begin
        if (HiLo_load) begin
            hi_r <= sel_mux_hi ? prod[63:32] : ((B != 0) ? A % B : 32'd0);
            lo_r <= sel_mux_lo ? prod[31:0]  : ((B != 0) ? A / B : 32'd0);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start_mult = 0; start_div = 0; abort = 0;
        mult_stop = 0; div_stop = 0; div_zero = 0;
    endtask

    // Outcome of one op from its event schedule (WAIT-cycle indices, 0 = never).
    function automatic void predict(input bit is_mult, input int stop_at, input int zero_at,
                                    input int abort_at, output int kind, output int w);
        kind = K_TO;
        w    = TO;
        for (int k = 1; k <= TO; k++) begin
            if (abort_at == k)              begin kind = K_ABORT; w = k; return; end
            if (!is_mult && zero_at == k)   begin kind = K_ZERO;  w = k; return; end
            if (stop_at == k)               begin kind = K_DONE;  w = k; return; end
        end
    endfunction

    task automatic run_txn(input bit is_mult, input bit both, input int stop_at,
                           input int zero_at, input int abort_at, input logic [31:0] a,
                           input logic [31:0] b, input int kind, input int w, input string tag);
        logic [31:0] hi0, lo0, hi_e, lo_e;
        logic [63:0] p;
        int n_mc = 0, n_dc = 0, n_ld = 0, n_dn = 0, n_dz = 0, n_to = 0;
        int ld_at = -1, ex_at = -1, cnt_obs = -1, sel_obs = -1;
        int busy_w = -1, busy_e = -1;
        int last, end_busy;
        bit may_start;
        A = a; B = b;
        hi0 = hi_r; lo0 = lo_r;
        p = {32'd0, a} * {32'd0, b};
        if (kind == K_DONE) begin
            hi_e = is_mult ? p[63:32] : ((b != 0) ? a % b : 32'd0);
            lo_e = is_mult ? p[31:0]  : ((b != 0) ? a / b : 32'd0);
        end else begin
            hi_e = hi0; lo_e = lo0;
        end
        last     = w + 4;
        end_busy = (kind == K_ABORT) ? w + 2 : w + 3;
        check({tag, "/idle0"}, busy, 0);
        start_mult = is_mult | both;
        start_div  = !is_mult | both;
        for (int e = 1; e <= last; e++) begin
            tick();
            n_mc += int'(mult_control); n_dc += int'(div_control);
            n_ld += int'(HiLo_load);    n_dn += int'(done);
            n_dz += int'(exc_div_zero); n_to += int'(exc_timeout);
            if (HiLo_load) begin ld_at = e; sel_obs = int'({sel_mux_hi, sel_mux_lo}); end
            if (exc_div_zero || exc_timeout) ex_at = e;
            if (e == w + 2) cnt_obs = int'(cycle_count);
            if (e == w + 1) busy_w = int'(busy);
            if (e == end_busy) busy_e = int'(busy);
            may_start  = (e < end_busy);
            start_mult = may_start ? 1'($urandom_range(0, 1)) : 1'b0;
            start_div  = may_start ? 1'($urandom_range(0, 1)) : 1'b0;
            mult_stop  = is_mult ? (stop_at > 0 && e == stop_at + 1) : 1'($urandom_range(0, 1));
            div_stop   = !is_mult ? (stop_at > 0 && e == stop_at + 1) : 1'($urandom_range(0, 1));
            div_zero   = !is_mult ? (zero_at > 0 && e == zero_at + 1) : 1'($urandom_range(0, 1));
            abort      = (abort_at > 0 && e == abort_at + 1) ||
                         (kind == K_DONE && e == w + 2 && 1'($urandom_range(0, 1)));
        end
        clear_inputs();
        check({tag, "/mult_ctl"}, n_mc, is_mult ? 1 : 0);
        check({tag, "/div_ctl"},  n_dc, is_mult ? 0 : 1);
        check({tag, "/hilo_cnt"}, n_ld, (kind == K_DONE) ? 1 : 0);
        check({tag, "/done_cnt"}, n_dn, (kind == K_DONE) ? 1 : 0);
        check({tag, "/exc_zero"}, n_dz, (kind == K_ZERO) ? 1 : 0);
        check({tag, "/exc_to"},   n_to, (kind == K_TO) ? 1 : 0);
        if (kind == K_DONE) begin
            check({tag, "/ld_cycle"}, ld_at, w + 2);
            check({tag, "/sel"}, sel_obs, is_mult ? 3 : 0);
        end
        if (kind == K_ZERO || kind == K_TO) check({tag, "/exc_cycle"}, ex_at, w + 2);
        check({tag, "/cycle_count"}, cnt_obs, (w < TO) ? w : TO - 1);
        check({tag, "/busy_wait"}, busy_w, 1);
        check({tag, "/busy_end"}, busy_e, 0);
        check({tag, "/hi"}, hi_r, hi_e);
        check({tag, "/lo"}, lo_r, lo_e);
    endtask

    typedef struct {
        bit          is_mult;
        bit          both;
        int          stop_at;
        int          zero_at;
        int          abort_at;
        logic [31:0] a;
        logic [31:0] b;
        int          kind;
        int          w;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int kind, w;
        vecs[0] = '{1, 0, 33, 0, 0, 32'd123456, 32'd789, K_DONE, 33};
        vecs[1] = '{0, 0, 32, 0, 0, 32'd100, 32'd7, K_DONE, 32};
        vecs[2] = '{0, 0, 0, 2, 0, 32'd100, 32'd0, K_ZERO, 2};
        vecs[3] = '{1, 0, 0, 0, 0, 32'd5, 32'd6, K_TO, 48};
        vecs[4] = '{1, 1, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, K_DONE, 1};
        vecs[5] = '{1, 0, 20, 0, 10, 32'd9, 32'd9, K_ABORT, 10};
        vecs[6] = '{0, 0, 5, 5, 0, 32'd50, 32'd0, K_ZERO, 5};
        vecs[7] = '{0, 0, 7, 0, 7, 32'd77, 32'd3, K_ABORT, 7};
        vecs[8] = '{1, 0, 48, 0, 0, 32'd1000, 32'd3000, K_DONE, 48};
        vecs[9] = '{0, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'd3, K_DONE, 1};

        // Reset state
        #12;
        check("rst/busy", busy, 0);
        check("rst/ctl", {mult_control, div_control}, 0);
        check("rst/hilo", {HiLo_load, done, exc_div_zero, exc_timeout}, 0);
        check("rst/sel", {sel_mux_hi, sel_mux_lo}, 0);
        check("rst/cnt", cycle_count, 0);
        tick();
        reset = 1'b1;
        tick();

        foreach (vecs[i])
            run_txn(vecs[i].is_mult, vecs[i].both, vecs[i].stop_at, vecs[i].zero_at,
                    vecs[i].abort_at, vecs[i].a, vecs[i].b, vecs[i].kind, vecs[i].w,
                    $sformatf("vec%0d", i));

        // Abort while launching: pulse still issued, then straight back to IDLE.
        start_mult = 1; tick(); start_mult = 0;
        check("abl/mult_ctl", mult_control, 1);
        abort = 1; tick(); abort = 0;
        check("abl/busy", busy, 0);
        check("abl/ctl", {mult_control, div_control}, 0);
        repeat (3) begin
            tick();
            check("abl/noload", {HiLo_load, exc_timeout}, 0);
        end

        for (int i = 0; i < 40; i++) begin
            bit is_mult, both;
            int st, zr, ab;
            is_mult = 1'($urandom_range(0, 1));
            both    = is_mult && ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 50));
            zr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 50)) : 0;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 50)) : 0;
            predict(is_mult, st, zr, ab, kind, w);
            run_txn(is_mult, both, st, zr, ab, $urandom, 32'($urandom_range(1, 100000)),
                    kind, w, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of WAIT.
        start_mult = 1; tick(); start_mult = 0;
        repeat (6) tick();
        check("arst/busy_before", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("arst/busy", busy, 0);
        check("arst/cnt", cycle_count, 0);
        check("arst/sel", {sel_mux_hi, sel_mux_lo}, 0);
        check("arst/pulses", {mult_control, div_control, HiLo_load, done, exc_div_zero, exc_timeout}, 0);
        tick();
        reset = 1'b1;
        mult_stop = 1;
        repeat (4) begin
            tick();
            check("arst/idle", {busy, HiLo_load, exc_timeout}, 0);
        end
        mult_stop = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
